localbus_master: RTL

- Localbus initiator that turns a valid/ready command stream (table writes, register reads) into localbus_ale/cs_n/rd_wr/data transactions.
- Drives the localbus responder inside the lookup/match path, which decodes the same signals.
- Sits between the host/control-plane command source and the lookup block's localbus port.
- Returns one response per command: read data, or completion with a timeout flag.

---
 rtl/lb_pkg.sv | 19 +
 rtl/localbus_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lb_pkg.sv
// Shared localbus definitions: FSM state encoding, direction constants and bus widths.
package lb_pkg;

   localparam int unsigned LB_DW = 32;
   localparam int unsigned CNT_W = 16;

   localparam logic LB_RD = 1'b1;
   localparam logic LB_WR = 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALE   = 3'd1,
      SETUP = 3'd2,
      CS    = 3'd3,
      REL   = 3'd4,
      RESP  = 3'd5
   } lb_state_e;

endpackage

// File: rtl/localbus_master.sv
// Localbus initiator: converts a valid/ready command stream into ALE/CS localbus
// transactions and returns one response (read data or completion) per command.
module localbus_master
   import lb_pkg::*;
#(
   parameter int unsigned      ALE_CYCLES = 2,
   parameter int unsigned      TIMEOUT    = 255,
   parameter logic [LB_DW-1:0] TO_DATA    = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [LB_DW-1:0] cmd_addr,
   input  logic [LB_DW-1:0] cmd_wdata,
   output logic             rsp_valid,
   output logic [LB_DW-1:0] rsp_rdata,
   output logic             rsp_timeout,
   output logic             localbus_cs_n,
   output logic             localbus_rd_wr,
   output logic [LB_DW-1:0] localbus_data,
   output logic             localbus_ale,
   input  logic             localbus_ack_n,
   input  logic [LB_DW-1:0] localbus_data_out
);

   localparam logic [CNT_W-1:0] ALE_LAST = CNT_W'(ALE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   lb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [LB_DW-1:0] addr_q, addr_d;
   logic [LB_DW-1:0] wdata_q, wdata_d;
   logic [LB_DW-1:0] rdata_q, rdata_d;
   logic             to_q, to_d;

   logic             ready_q, ready_d;
   logic             cs_n_q, cs_n_d;
   logic             ale_q, ale_d;
   logic             rd_wr_q, rd_wr_d;
   logic [LB_DW-1:0] data_q, data_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [LB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic             rsp_to_q, rsp_to_d;

   // State register plus transaction context and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         to_q        <= 1'b0;
         ready_q     <= 1'b0;
         cs_n_q      <= 1'b1;
         ale_q       <= 1'b0;
         rd_wr_q     <= LB_RD;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         to_q        <= to_d;
         ready_q     <= ready_d;
         cs_n_q      <= cs_n_d;
         ale_q       <= ale_d;
         rd_wr_q     <= rd_wr_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_to_q    <= rsp_to_d;
      end
   end

   // Next-state, command capture and per-phase wait counter
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      to_d    = to_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               wr_d    = cmd_wr;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               to_d    = 1'b0;
               state_d = ALE;
            end
         end
         ALE: begin
            if (cnt_q == ALE_LAST) state_d = SETUP;
         end
         SETUP: state_d = CS;
         CS: begin
            if (!localbus_ack_n) begin
               if (!wr_q) rdata_d = localbus_data_out;
               state_d = REL;
            end else if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               state_d = REL;
            end
         end
         REL: begin
            if (localbus_ack_n) begin
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Restart on every phase change; saturate so a long phase never wraps
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == '1) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Output decode from the upcoming state so every output is a flop
   always_comb begin
      ready_d     = 1'b0;
      cs_n_d      = 1'b1;
      ale_d       = 1'b0;
      rd_wr_d     = LB_RD;
      data_d      = '0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_to_d    = 1'b0;
      unique case (state_d)
         IDLE: ready_d = 1'b1;
         ALE: begin
            ale_d   = 1'b1;
            rd_wr_d = wr_d ? LB_WR : LB_RD;
            data_d  = addr_d;
         end
         SETUP: begin
            rd_wr_d = wr_d ? LB_WR : LB_RD;
            data_d  = addr_d;
         end
         CS: begin
            cs_n_d  = 1'b0;
            rd_wr_d = wr_d ? LB_WR : LB_RD;
            data_d  = wr_d ? wdata_d : '0;
         end
         REL: ;
         RESP: begin
            rsp_valid_d = 1'b1;
            rsp_to_d    = to_d;
            rsp_rdata_d = wr_d ? '0 : (to_d ? TO_DATA : rdata_d);
         end
         default: ;
      endcase
   end

   assign cmd_ready      = ready_q;
   assign localbus_cs_n  = cs_n_q;
   assign localbus_ale   = ale_q;
   assign localbus_rd_wr = rd_wr_q;
   assign localbus_data  = data_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_timeout    = rsp_to_q;

endmodule
